// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline hazard/forwarding controller (stage enables/flushes, EX/ID bypass selects, stall counter, memory timeout)
// Inputs: ID/EX/MEM/WB register ids and write/load/store flags, mem_ready handshake, MEM-resolved redirect.
// Outputs: pc/ifid/idex/exmem/memwb enables and flushes, fwd_a/fwd_b/fwd_id_rt, stall_cycles, mem_timeout.
module pipe_hazard_ctrl #(
  parameter int unsigned REGW     = 5,
  parameter int unsigned LOAD_LAT = 0,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_jump,
  input  logic [REGW-1:0] ex_rs,
  input  logic [REGW-1:0] ex_rt,
  input  logic [REGW-1:0] ex_wreg,
  input  logic            ex_memread,
  input  logic [REGW-1:0] mem_wreg,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic            mem_memwrite,
  input  logic            mem_ready,
  input  logic            redirect,
  input  logic [REGW-1:0] wb_wreg,
  input  logic            wb_regwrite,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_en,
  output logic            idex_flush,
  output logic            exmem_en,
  output logic            exmem_flush,
  output logic            memwb_en,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            fwd_id_rt,
  output logic [CNTW-1:0] stall_cycles,
  output logic            mem_timeout
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  localparam logic [2:0] LAT3 = 3'(LOAD_LAT);
  localparam logic [7:0] WM8  = 8'(WAIT_MAX);
  state_t          state_q, state_d;
  logic [2:0]      lcnt_q, lcnt_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic            tout_q, tout_d;
  logic            frozen, lu_hit;
  assign frozen = (mem_memread | mem_memwrite) & ~mem_ready;
  assign lu_hit = ex_memread && ex_wreg != '0 && (ex_wreg == id_rs || ex_wreg == id_rt);
  assign fwd_a = (ex_rs != '0 && ex_rs == mem_wreg && mem_regwrite && !mem_memread) ? 2'b10 :
                 (ex_rs != '0 && ex_rs == wb_wreg && wb_regwrite) ? 2'b01 : 2'b00;
  assign fwd_b = (ex_rt != '0 && ex_rt == mem_wreg && mem_regwrite && !mem_memread) ? 2'b10 :
                 (ex_rt != '0 && ex_rt == wb_wreg && wb_regwrite) ? 2'b01 : 2'b00;
  assign fwd_id_rt    = id_rt != '0 && id_rt == wb_wreg && wb_regwrite;
  assign stall_cycles = stall_q;
  // timeout is visible in the very wait cycle that reaches WAIT_MAX, then held by tout_q
  assign mem_timeout  = tout_d;
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    if (frozen) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = MEM_WAIT;
    end else if (redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      lcnt_d      = '0;
      state_d     = RUN;
    end else if ((state_q == RUN && lu_hit) || state_q == LU_STALL) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      lcnt_d     = (state_q == LU_STALL) ? lcnt_q - 3'd1 : LAT3;
      state_d    = (state_q == LU_STALL) ? ((lcnt_q == 3'd1) ? RUN : LU_STALL) :
                   ((LOAD_LAT > 0) ? LU_STALL : RUN);
    end else begin
      ifid_flush = id_jump;
      state_d    = RUN;
    end
    wcnt_d  = frozen ? ((wcnt_q >= WM8) ? wcnt_q : wcnt_q + 8'd1) : 8'd0;
    tout_d  = tout_q | (frozen && wcnt_d == WM8);
    stall_d = (!pc_en && stall_q != '1) ? stall_q + CNTW'(1) : stall_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      lcnt_q  <= '0;
      wcnt_q  <= '0;
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      tout_q  <= tout_d;
    end
  end
endmodule
